// File: rtl/fifo_defs.sv
// Shared definitions for the dual-clock FIFO and its read-side stream adapter.
package fifo_defs;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_TWO   = 2'd2;
endpackage

// File: rtl/fifo_rd_stream_skid2.sv
// Two-entry output buffer (head + skid) with push/pop/flush; head drives the stream.
module stream_skid2
  import fifo_defs::*;
#(
  parameter int data_width = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [data_width-1:0] push_data,
  input  logic                  ready,
  output logic [data_width-1:0] out_data,
  output logic                  out_valid,
  output logic                  pop,
  output occ_t                  occ
);

  occ_t                  occ_q, occ_d;
  logic [data_width-1:0] head_q, head_d;
  logic [data_width-1:0] skid_q, skid_d;

  always_comb begin
    pop    = (occ_q != OCC_EMPTY) && ready;
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      if (pop && occ_q == OCC_TWO) head_d = skid_q;
      // A word lands in the head only if the head is (or is becoming) free.
      if (push) begin
        if (occ_q == OCC_EMPTY || (occ_q == OCC_ONE && pop)) head_d = push_data;
        else                                                  skid_d = push_data;
      end
      case ({push, pop})
        2'b10:   occ_d = occ_t'(occ_q + 2'd1);
        2'b01:   occ_d = occ_t'(occ_q - 2'd1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  assign out_data  = head_q;
  assign out_valid = (occ_q != OCC_EMPTY);
  assign occ       = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain: pops into a 2-entry buffer and presents a framed valid/ready stream.
module fifo_rd_stream
  import fifo_defs::*;
#(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int frame_len  = 16,
  parameter int cnt_width  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [data_width-1:0] rdata,
  input  logic                  rempty,
  output logic                  rinc,
  input  logic                  enable,
  input  logic                  flush,
  output logic [data_width-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [cnt_width-1:0]  beat_count,
  output logic [cnt_width-1:0]  frame_count
);

  localparam logic [15:0]          LAST_IDX = 16'(frame_len - 1);
  localparam logic [cnt_width-1:0] CNT_ONE  = cnt_width'(1);

  occ_t occ;
  logic pop;
  logic beat_ok;

  logic [15:0]          bidx_q, bidx_d;
  logic [cnt_width-1:0] beat_count_q, beat_count_d;
  logic [cnt_width-1:0] frame_count_q, frame_count_d;

  // Gating uses only registered occupancy and rempty, so m_ready never reaches rinc.
  assign rinc = !rrst && !flush && enable && !rempty && (occ != OCC_TWO);

  stream_skid2 #(.data_width(data_width)) u_skid (
    .clk       (rclk),
    .rst       (rrst),
    .flush     (flush),
    .push      (rinc),
    .push_data (rdata),
    .ready     (m_ready),
    .out_data  (m_data),
    .out_valid (m_valid),
    .pop       (pop),
    .occ       (occ)
  );

  assign beat_ok = pop && !flush;
  assign m_last  = m_valid && (bidx_q == LAST_IDX);

  always_comb begin
    bidx_d        = bidx_q;
    beat_count_d  = beat_count_q;
    frame_count_d = frame_count_q;
    if (flush) begin
      bidx_d = '0;
    end else if (beat_ok) begin
      bidx_d       = (bidx_q == LAST_IDX) ? 16'd0 : bidx_q + 16'd1;
      beat_count_d = beat_count_q + CNT_ONE;
      if (m_last) frame_count_d = frame_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      bidx_q        <= '0;
      beat_count_q  <= '0;
      frame_count_q <= '0;
    end else begin
      bidx_q        <= bidx_d;
      beat_count_q  <= beat_count_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign beat_count  = beat_count_q;
  assign frame_count = frame_count_q;

endmodule
